popcount_scheduler: RTL and testbench

Round-robin scheduler that shares one popcount datapath between `NUM_REQ` requesters. It accepts one job at a time: a word count plus a stream of data words. It sums the set bits across the whole stream and returns the total tagged with the requester ID. It sits between the requester masters and the single popcount engine behind the PopCount AXI4-Lite register block.

---
 rtl/popcount_pkg.sv | 21 ++
 rtl/popcount_unit.sv | 41 ++++
 rtl/popcount_scheduler.sv | 165 ++++++++++++++++
 tb/tb_popcount_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared types and helpers for the popcount scheduler slice.
//   state_t   : scheduler FSM states
//   cnt_width : width of the per-job bit total for a given length/word width
// -----------------------------------------------------------------------------
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Enough bits for (2^len_w - 1) words each carrying up to data_w set bits.
    function automatic int cnt_width(input int len_w, input int data_w);
        return len_w + $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/popcount_unit.sv
// -----------------------------------------------------------------------------
// popcount_unit
// Registered population count of one data word, one cycle of latency.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   in_valid, in_data    : word to count
//   out_valid, out_count : set-bit count of the word presented last cycle
// -----------------------------------------------------------------------------
module popcount_unit #(
    parameter  int DATA_WIDTH = 32,
    localparam int OUT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_count
);

    logic [OUT_WIDTH-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            ones = ones + OUT_WIDTH'(in_data[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= in_valid;
            // Count only moves on a real word so a stale value never lingers.
            if (in_valid)
                out_count <= ones;
        end
    end

endmodule

// File: rtl/popcount_scheduler.sv
// -----------------------------------------------------------------------------
// popcount_scheduler
// Round-robin arbiter in front of a single popcount datapath. One job at a
// time: a requester is accepted with a word count, streams that many words on
// the shared data bus, and gets back the total number of set bits tagged with
// its index.
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   req_valid/req_len       : per-requester job request and word count
//   req_ready               : one-hot job accept (IDLE only)
//   grant                   : one-hot owner of the data bus (STREAM/FLUSH)
//   data_valid/data_in      : granted requester's word stream
//   data_ready              : word accepted this cycle (STREAM only)
//   res_valid/res_id/res_count/res_ready : result handshake
//   busy                    : scheduler is not idle
// -----------------------------------------------------------------------------
module popcount_scheduler
    import popcount_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int LEN_WIDTH  = 8,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CNT_WIDTH  = cnt_width(LEN_WIDTH, DATA_WIDTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*LEN_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           grant,
    input  logic                         data_valid,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         data_ready,
    output logic                         res_valid,
    output logic [IDX_W-1:0]             res_id,
    output logic [CNT_WIDTH-1:0]         res_count,
    input  logic                         res_ready,
    output logic                         busy
);

    localparam int PC_W = $clog2(DATA_WIDTH + 1);

    // First requester at or above ptr, wrapping. Returns {found, index}.
    // Scanning offsets high to low lets the smallest offset win.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] r;
        int             idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx])
                r = {1'b1, IDX_W'(idx)};
        end
        return r;
    endfunction

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx;
    logic [LEN_WIDTH-1:0] remaining;
    logic [CNT_WIDTH-1:0] acc;

    logic [IDX_W:0]       pick;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [LEN_WIDTH-1:0] win_len;
    logic                 accept;
    logic                 xfer;
    logic                 last_xfer;

    logic                 pc_valid;
    logic [PC_W-1:0]      pc_count;

    assign pick      = rr_pick(req_valid, rr_ptr);
    assign win_vld   = pick[IDX_W];
    assign win_idx   = pick[IDX_W-1:0];
    assign win_len   = req_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    assign accept    = (state == ST_IDLE) && win_vld;
    assign xfer      = (state == ST_STREAM) && data_valid;
    assign last_xfer = xfer && (remaining == LEN_WIDTH'(1));

    popcount_unit #(.DATA_WIDTH(DATA_WIDTH)) u_pc (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (xfer),
        .in_data   (data_in),
        .out_valid (pc_valid),
        .out_count (pc_count)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)
                           state_nxt = (win_len == '0) ? ST_RESULT : ST_STREAM;
            ST_STREAM: if (last_xfer)
                           state_nxt = ST_FLUSH;
            // The last word's count lands in acc during this cycle.
            ST_FLUSH:  state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready)
                           state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        req_ready  = '0;
        grant      = '0;
        data_ready = 1'b0;
        res_valid  = 1'b0;
        res_id     = '0;
        res_count  = '0;
        busy       = (state != ST_IDLE);
        case (state)
            // reset gating keeps req_ready low while reset is held even
            // though the request inputs may still be asserted.
            ST_IDLE:   if (win_vld && !reset)
                           req_ready[win_idx] = 1'b1;
            ST_STREAM: begin
                grant[idx] = 1'b1;
                data_ready = 1'b1;
            end
            ST_FLUSH:  grant[idx] = 1'b1;
            ST_RESULT: begin
                res_valid = 1'b1;
                res_id    = idx;
                res_count = acc;
            end
            default: ;
        endcase
    end

    // ---- job datapath ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            idx       <= '0;
            remaining <= '0;
            acc       <= '0;
        end else if (accept) begin
            idx       <= win_idx;
            remaining <= win_len;
            acc       <= '0;
            rr_ptr    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end else begin
            if (xfer)
                remaining <= remaining - LEN_WIDTH'(1);
            if (pc_valid)
                acc <= acc + CNT_WIDTH'(pc_count);
        end
    end

endmodule

// File: tb/tb_popcount_scheduler.sv
// -----------------------------------------------------------------------------
// tb_popcount_scheduler
// Directed, table-driven bench for popcount_scheduler plus hand-written
// sequences for round-robin order, full-length jobs and reset mid-job.
// -----------------------------------------------------------------------------
module tb_popcount_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int IW = 2;
    localparam int CW = 14;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic              data_valid;
    logic [DW-1:0]     data_in;
    logic              data_ready;
    logic              res_valid;
    logic [IW-1:0]     res_id;
    logic [CW-1:0]     res_count;
    logic              res_ready;
    logic              busy;

    popcount_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .grant      (grant),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_count  (res_count),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] wbuf [0:255];

    typedef struct {
        int              id;
        int              len;
        logic [3:0][31:0] w;
        logic [3:0]      stall;
        int              hold;
        int              exp_cnt;
        int              exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic set_len(input int len);
        for (int i = 0; i < NR; i++)
            req_len[i*LW +: LW] = LW'(len);
    endtask

    task automatic reset_outputs_zero();
        check("rst_req_ready",  32'(req_ready),  0);
        check("rst_grant",      32'(grant),      0);
        check("rst_data_ready", 32'(data_ready), 0);
        check("rst_res_valid",  32'(res_valid),  0);
        check("rst_res_id",     32'(res_id),     0);
        check("rst_res_count",  32'(res_count),  0);
        check("rst_busy",       32'(busy),       0);
    endtask

    // One complete job: request, stream wbuf[0..len-1], collect the result.
    task automatic run_job(input logic [NR-1:0] mask, input int exp_id, input int len,
                           input logic [3:0] stall, input int hold,
                           input int exp_cnt, input int exp_lat);
        int            t_acc, k, s, t, bad;
        logic          xfer;
        logic [NR-1:0] g;
        g   = NR'(1) << exp_id;
        bad = 0;
        req_valid  = mask;
        set_len(len);
        res_ready  = 1'b0;
        data_valid = 1'b0;
        #1;
        t = 0;
        while (req_ready == '0 && t < 50) begin
            @(posedge clock); #1; t++;
        end
        check("accept_onehot", 32'(req_ready), 32'(g));
        t_acc = cyc;
        @(posedge clock); #1;
        req_valid = '0;
        k = 0; s = 0;
        while (k < len && s < 600) begin
            data_valid = (s < 4) ? !stall[s] : 1'b1;
            data_in    = wbuf[k];
            #1;
            if (data_ready !== 1'b1 || grant !== g) bad++;
            xfer = data_valid & data_ready;
            @(posedge clock); #1;
            if (xfer) k++;
            s++;
        end
        data_valid = 1'b0;
        data_in    = '0;
        res_ready  = (hold == 0);
        #1;
        t = 0;
        while (res_valid !== 1'b1 && t < 20) begin
            if (data_ready !== 1'b0 || grant !== ((len > 0) ? g : '0)) bad++;
            @(posedge clock); #1; t++;
        end
        check("res_latency", 32'(cyc - t_acc), 32'(exp_lat));
        check("res_id",      32'(res_id),      32'(exp_id));
        check("res_count",   32'(res_count),   32'(exp_cnt));
        check("grant_result", 32'(grant),      0);
        for (int h = 0; h < hold; h++) begin
            if (res_valid !== 1'b1 || res_id !== IW'(exp_id) ||
                res_count !== CW'(exp_cnt) || busy !== 1'b1) bad++;
            @(posedge clock); #1;
        end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        #1;
        check("idle_after_result", 32'(busy), 0);
        check("protocol",          32'(bad),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // id len words{w3,w2,w1,w0} stall hold count latency
        vecs[0] = '{0, 3, {32'h0, 32'h0000000F, 32'hFFFFFFFF, 32'h00000001}, 4'b0000, 0, 37, 5};
        vecs[1] = '{2, 0, {32'h0, 32'h0, 32'h0, 32'h0},                      4'b0000, 0,  0, 1};
        vecs[2] = '{1, 2, {32'h0, 32'h0, 32'h000000FF, 32'h000000FF},        4'b0110, 5, 16, 6};
        vecs[3] = '{3, 4, {32'h0, 32'hAAAAAAAA, 32'h7, 32'h80000000},        4'b0000, 0, 20, 6};
        vecs[4] = '{1, 1, {32'h0, 32'h0, 32'h0, 32'h80000000},               4'b0000, 1,  1, 3};

        // Reset with requests and data pending: every output must read 0.
        reset      = 1'b1;
        req_valid  = '1;
        set_len(3);
        data_valid = 1'b1;
        data_in    = '1;
        res_ready  = 1'b0;
        #2;
        reset_outputs_zero();
        @(posedge clock); @(posedge clock); #1;
        reset      = 1'b0;
        req_valid  = '0;
        data_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) wbuf[j] = vecs[i].w[j];
            run_job(NR'(1) << vecs[i].id, vecs[i].id, vecs[i].len, vecs[i].stall,
                    vecs[i].hold, vecs[i].exp_cnt, vecs[i].exp_lat);
        end

        // Round-robin from a fresh pointer: all requesters busy, order 0,1,2,3,0.
        reset = 1'b1; #1; @(posedge clock); #1; reset = 1'b0;
        wbuf[0] = 32'h3;
        for (int j = 0; j < 5; j++)
            run_job('1, j % NR, 1, 4'b0000, 0, 2, 3);

        // Full-length job.
        for (int j = 0; j < 256; j++) wbuf[j] = 32'hFFFFFFFF;
        run_job(4'b0001, 0, 255, 4'b0000, 0, 8160, 257);

        // Reset mid-job (req 2, 2 of 4 words streamed). Afterwards req 1 and
        // req 3 compete: a restarted pointer picks 1, a stale one would pick 3.
        req_valid = 4'b0100;
        set_len(4);
        #1;
        check("midjob_accept", 32'(req_ready), 32'h4);
        @(posedge clock); #1;
        req_valid  = '0;
        data_valid = 1'b1;
        data_in    = 32'hFFFFFFFF;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset     = 1'b1;
        req_valid = '1;
        #1;
        reset_outputs_zero();
        @(posedge clock); #1;
        reset      = 1'b0;
        req_valid  = '0;
        data_valid = 1'b0;
        wbuf[0] = 32'h80000000;
        run_job(4'b1010, 1, 1, 4'b0000, 0, 1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
